// File: rtl/immediate_decode_pipe.sv
// Pipelined immediate decoder with a 2-entry output FIFO (XLEN = 32 or 64).
// Define IMM_ILLEGAL_EN to add a per-entry out_illegal flag.
module immediate_decode_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_zimm,
    output logic [XLEN-1:0] out_target
`ifdef IMM_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_CSR  = 3'd6;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("immediate_decode_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // Combinational decode of the offered instruction
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [4:0]      dec_zimm;
    logic            dec_pc_rel;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;

    always_comb begin
        dec_fmt    = FMT_NONE;
        dec_imm32  = 32'h0;
        dec_zimm   = 5'h0;
        dec_pc_rel = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt    = FMT_B;
                dec_pc_rel = 1'b1;
                dec_imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_instr[31:12], 12'h0};
            end
            7'b0010111: begin
                dec_fmt    = FMT_U;
                dec_pc_rel = 1'b1;
                dec_imm32  = {in_instr[31:12], 12'h0};
            end
            7'b1101111: begin
                dec_fmt    = FMT_J;
                dec_pc_rel = 1'b1;
                dec_imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                // CSR address is zero-extended, so bit 31 of imm32 stays 0
                dec_fmt   = FMT_CSR;
                dec_imm32 = {20'h0, in_instr[31:20]};
                dec_zimm  = in_instr[19:15];
            end
            default: begin
                dec_fmt = FMT_NONE;
            end
        endcase
    end

    assign dec_imm    = XLEN'($signed(dec_imm32));
    assign dec_target = in_pc + (dec_pc_rel ? dec_imm : {{(XLEN-3){1'b0}}, 3'd4});

`ifdef IMM_ILLEGAL_EN
    logic dec_illegal;
    assign dec_illegal = (dec_fmt == FMT_NONE) || (in_instr[1:0] != 2'b11);
`endif

    // Handshake: input moves on in_valid & in_ready, output on out_valid & out_ready.
    // in_ready is a register (count < 2 after the edge), so out_ready never reaches it combinationally.
    logic [1:0]      count;
    logic [1:0]      count_next;
    logic            head;
    logic            wr_idx;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] imm_q    [2];
    logic [XLEN-1:0] target_q [2];
    logic [2:0]      fmt_q    [2];
    logic [4:0]      zimm_q   [2];
`ifdef IMM_ILLEGAL_EN
    logic            ill_q    [2];
`endif

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign wr_idx     = head ^ count[0];
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= 2'd0;
            head     <= 1'b0;
            in_ready <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i]    <= '0;
                target_q[i] <= '0;
                fmt_q[i]    <= 3'd0;
                zimm_q[i]   <= 5'd0;
`ifdef IMM_ILLEGAL_EN
                ill_q[i]    <= 1'b0;
`endif
            end
        end else if (flush) begin
            count    <= 2'd0;
            head     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                imm_q[wr_idx]    <= dec_imm;
                target_q[wr_idx] <= dec_target;
                fmt_q[wr_idx]    <= dec_fmt;
                zimm_q[wr_idx]   <= dec_zimm;
`ifdef IMM_ILLEGAL_EN
                ill_q[wr_idx]    <= dec_illegal;
`endif
            end
            if (pop) begin
                head <= ~head;
            end
            count    <= count_next;
            in_ready <= (count_next != 2'd2);
        end
    end

    assign out_valid  = (count != 2'd0);
    assign out_imm    = imm_q[head];
    assign out_target = target_q[head];
    assign out_fmt    = fmt_q[head];
    assign out_zimm   = zimm_q[head];
`ifdef IMM_ILLEGAL_EN
    assign out_illegal = ill_q[head];
`endif

endmodule
